// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit seven-segment driver with inter-digit
// blanking, 16-level PWM dimming and frame-synchronous shadow pattern updates.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [3:0] brightness_i,
    input  logic [7:0] seg_in0_i,
    input  logic [7:0] seg_in1_i,
    input  logic [7:0] seg_in2_i,
    input  logic [7:0] seg_in3_i,
    input  logic       upd_valid_i,
    output logic       upd_ready_o,
    output logic [3:0] an_o,
    output logic [7:0] seg_o,
    output logic [1:0] digit_idx_o,
    output logic       frame_start_o
);
    localparam int SW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SW-1:0] LAST = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLK  = SW'(BLANK_CYC);

    typedef enum logic [1:0] {IDLE, BLANK, LIT} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [1:0]    dig_q, dig_d;
    logic [7:0]    shadow_q [4];
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    idx_q;
    logic          fs_q, fs_d;
    logic          rdy_q, rdy_d;
    logic          lit_d;
    logic          xfer;

    assign xfer          = upd_valid_i && rdy_q;
    assign upd_ready_o   = rdy_q;
    assign an_o          = an_q;
    assign seg_o         = seg_q;
    assign digit_idx_o   = idx_q;
    assign frame_start_o = fs_q;

    // Output registers load from next-state values so they line up with the state they describe.
    always_comb begin
        state_d = IDLE;
        slot_d  = '0;
        pwm_d   = '0;
        dig_d   = '0;
        fs_d    = 1'b0;
        if (enable_i) begin
            if (state_q == IDLE) begin
                fs_d = 1'b1;
            end else if (slot_q == LAST) begin
                dig_d = dig_q + 2'd1;
                fs_d  = dig_q == 2'd3;
            end else begin
                slot_d = slot_q + 1'b1;
                dig_d  = dig_q;
                pwm_d  = (state_q == LIT) ? pwm_q + 4'd1 : 4'd0;
            end
            state_d = (slot_d >= BLK) ? LIT : BLANK;
        end
        lit_d = (state_d == LIT) && (pwm_d <= brightness_i);
        an_d  = lit_d ? ~(4'b0001 << dig_d) : 4'hF;
        seg_d = lit_d ? shadow_q[dig_d] : 8'hFF;
        rdy_d = (state_d == IDLE) || (dig_d == 2'd3 && slot_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            pwm_q    <= '0;
            dig_q    <= '0;
            an_q     <= 4'hF;
            seg_q    <= 8'hFF;
            idx_q    <= '0;
            fs_q     <= 1'b0;
            rdy_q    <= 1'b0;
            shadow_q <= '{default: 8'hFF};
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            idx_q   <= dig_d;
            fs_q    <= fs_d;
            rdy_q   <= rdy_d;
            if (xfer) shadow_q <= '{seg_in0_i, seg_in1_i, seg_in2_i, seg_in3_i};
        end
    end
endmodule
